vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
- Sequences the 640x480 colour pattern generator and any later pixel sources. Produces the raster scan position (row/col), the active-video qualifier, and the VGA sync pulses.
- The sync pulses are delayed by a configurable number of pixel ticks so they line up with registered colour outputs downstream.
- Also provides a frame-start pulse and an 8-bit frame counter for height-sensor display scheduling.
- Sits between the pixel clock domain root and the pattern/colour datapath.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of vgahsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vgavsync
- PIPE_DELAY, 1, pixel ticks of delay applied to the syncs; legal range 0..4

Ports:
- vgaclock  in  1  pixel clock
- vgareset  in  1  synchronous active-high reset
- vgaenable  in  1  pixel tick enable; tie high when vgaclock is already the pixel rate
- vgacol  out  10  current column counter, 0..H_TOTAL-1
- vgarow  out  10  current row counter, 0..V_TOTAL-1
- vgavalid  out  1  high when running and in the active region
- vgahsync  out  1  horizontal sync, delayed by PIPE_DELAY
- vgavsync  out  1  vertical sync, delayed by PIPE_DELAY
- vgaframestart  out  1  high while running and counters = (0,0)
- vgaframecount  out  8  count of completed frames, wraps at 255

Behaviour:
- Derived values: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both must be ≤1024 (elaboration-time check).
- Reset is synchronous. At any vgaclock edge with vgareset=1, all outputs take their reset values, including mid-frame:
  - state=IDLE
  - vgacol=0, vgarow=0, vgavalid=0, vgaframestart=0, vgaframecount=0
  - vgahsync=~HSYNC_POL, vgavsync=~VSYNC_POL
  - all sync delay stages = deasserted
- FSM, horizontal phase with idle:
  - IDLE -> H_ACT on the first edge with vgaenable=1; counters stay (0,0) on that edge, so (0,0) is presented as active.
  - H_ACT (col<H_ACTIVE) -> H_FP -> H_SYNC -> H_BP -> H_ACT, following col boundaries.
  - State is a pure function of col while running.
- Counters (running states, enabled edges only):
  - col increments; at H_TOTAL-1 it wraps to 0 and row increments.
  - row wraps from V_TOTAL-1 to 0 on the same edge that col wraps.
  - vgaframecount increments by 1 on the (H_TOTAL-1, V_TOTAL-1) -> (0,0) edge, modulo 256.
- vgaenable=0: counters, state, frame count and delay stages all hold, so every output holds.
- vgavalid: combinational decode of registered state = (state!=IDLE) && col<H_ACTIVE && row<V_ACTIVE.
- Raw syncs:
  - hsync_raw asserted for col in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] (656..751).
  - vsync_raw asserted for row in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] (490..491).
  - Both deasserted in IDLE.
- Sync delay:
  - Raw syncs pass through a PIPE_DELAY-deep shift register that advances only on enabled edges.
  - PIPE_DELAY=0 drives the raw decode directly.
  - Output level is POL when asserted, ~POL otherwise.
- Latency: a pattern generator that registers colour from vgarow/vgacol/vgavalid produces colour one pixel later. PIPE_DELAY=1 aligns the syncs with that colour.
- vgaframestart: decode, high for exactly one enabled tick per frame. It stays high through any vgaenable=0 cycles while the counters sit at (0,0).

Test Plan:
- Reset, then vgaenable held high: first running cycle shows col=0, row=0, vgavalid=1. After 640 enabled edges, col=640 and vgavalid=0. After 800 edges, col=0, row=1, vgavalid=1.
- PIPE_DELAY=1, HSYNC_POL=0: vgahsync is low for exactly 96 consecutive edges. The first low cycle has col=657; high again at col=753.
- vgavsync is low for exactly 1600 enabled edges, starting at row=490, col=1 and ending after row=492, col=0.
- Frame wrap: at (799,524) the next edge gives (0,0), vgaframecount 0->1, and vgaframestart high for one cycle. Run 256 frames: count wraps 255->0.
- vgaenable pulsed 1-in-4: outputs change only on enabled edges; one full frame takes 1,680,000 vgaclock cycles; the hsync width is 384 clocks.
- Assert vgareset for one cycle at row=300, col=100: the next cycle shows all reset values with state IDLE. With vgaenable held 0, outputs stay at reset values. When vgaenable rises, the scan restarts at (0,0).

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: col/row scan, active-video qualifier, delayed sync pulses, frame start/count.
// Everything advances only on vgaenable ticks, so a divided pixel rate just stretches the same raster.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   PIPE_DELAY = 1
) (
  input  logic       vgaclock,
  input  logic       vgareset,
  input  logic       vgaenable,
  output logic [9:0] vgacol,
  output logic [9:0] vgarow,
  output logic       vgavalid,
  output logic       vgahsync,
  output logic       vgavsync,
  output logic       vgaframestart,
  output logic [7:0] vgaframecount
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // 11-bit bounds so a 1024-wide raster still compares correctly against 10-bit counters
  localparam logic [10:0] HA_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VA_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_err
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_delay_err
    $error("vga_timing_ctrl: PIPE_DELAY must be in 0..4");
  end

  typedef enum logic [2:0] {S_IDLE, S_HACT, S_HFP, S_HSYNC, S_HBP} state_t;

  state_t      state;
  logic [9:0]  col_nxt;
  logic [9:0]  row_nxt;
  logic        col_wrap;
  logic        row_wrap;
  logic        running;
  logic [10:0] row_x;
  logic        hs_raw;
  logic        vs_raw;
  logic        hs_del;
  logic        vs_del;

  function automatic state_t hphase(input logic [10:0] c);
    if (c < HA_END)      return S_HACT;
    else if (c < HS_BEG) return S_HFP;
    else if (c < HS_END) return S_HSYNC;
    else                 return S_HBP;
  endfunction

  always_comb begin
    col_wrap = (vgacol == H_LAST);
    row_wrap = (vgarow == V_LAST);
    col_nxt  = col_wrap ? 10'd0 : vgacol + 10'd1;
    row_nxt  = row_wrap ? 10'd0 : vgarow + 10'd1;
  end

  // Leaving IDLE keeps the counters at (0,0) so the first pixel is presented as active
  always_ff @(posedge vgaclock) begin
    if (vgareset) begin
      state         <= S_IDLE;
      vgacol        <= '0;
      vgarow        <= '0;
      vgaframecount <= '0;
    end else if (vgaenable) begin
      if (state == S_IDLE) begin
        state <= hphase(11'd0);
      end else begin
        vgacol <= col_nxt;
        state  <= hphase({1'b0, col_nxt});
        if (col_wrap) begin
          vgarow <= row_nxt;
          if (row_wrap) vgaframecount <= vgaframecount + 8'd1;
        end
      end
    end
  end

  assign running       = (state != S_IDLE);
  assign row_x         = {1'b0, vgarow};
  assign vgavalid      = (state == S_HACT) && (row_x < VA_END);
  assign vgaframestart = running && (vgacol == 10'd0) && (vgarow == 10'd0);
  assign hs_raw        = (state == S_HSYNC);
  assign vs_raw        = running && (row_x >= VS_BEG) && (row_x < VS_END);

  // Stages hold the asserted/deasserted flag; polarity is applied only at the pins
  if (PIPE_DELAY == 0) begin : g_nodelay
    assign hs_del = hs_raw;
    assign vs_del = vs_raw;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;
    always_ff @(posedge vgaclock) begin
      if (vgareset) begin
        hs_pipe <= '0;
        vs_pipe <= '0;
      end else if (vgaenable) begin
        hs_pipe <= (hs_pipe << 1) | PIPE_DELAY'(hs_raw);
        vs_pipe <= (vs_pipe << 1) | PIPE_DELAY'(vs_raw);
      end
    end
    assign hs_del = hs_pipe[PIPE_DELAY-1];
    assign vs_del = vs_pipe[PIPE_DELAY-1];
  end

  assign vgahsync = hs_del ? HSYNC_POL : ~HSYNC_POL;
  assign vgavsync = vs_del ? VSYNC_POL : ~VSYNC_POL;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: a full 640x480 instance for first-line checks, and a 16x12 raster instance for frame-level corners.
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       valid;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int   n;
    logic en;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic [9:0] s_col, s_row, f_col, f_row;
  logic       s_valid, s_hs, s_vs, s_fs, f_valid, f_hs, f_vs, f_fs;
  logic [7:0] s_fc, f_fc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Small raster: H 8+2+3+3=16, V 6+2+2+2=12, active-high vsync
  vga_timing_ctrl #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .PIPE_DELAY(1)
  ) dut (
    .vgaclock(clk), .vgareset(rst), .vgaenable(en),
    .vgacol(s_col), .vgarow(s_row), .vgavalid(s_valid),
    .vgahsync(s_hs), .vgavsync(s_vs), .vgaframestart(s_fs), .vgaframecount(s_fc)
  );

  vga_timing_ctrl dut_full (
    .vgaclock(clk), .vgareset(rst), .vgaenable(en),
    .vgacol(f_col), .vgarow(f_row), .vgavalid(f_valid),
    .vgahsync(f_hs), .vgavsync(f_vs), .vgaframestart(f_fs), .vgaframecount(f_fc)
  );

  function automatic obs_t mk(input int col, input int row, input logic v, input logic hs,
                              input logic vs, input logic fs, input int fc);
    obs_t o;
    o.col = 10'(col); o.row = 10'(row); o.valid = v; o.hs = hs; o.vs = vs; o.fs = fs; o.fc = 8'(fc);
    return o;
  endfunction

  function automatic obs_t s_obs();
    return mk(int'(s_col), int'(s_row), s_valid, s_hs, s_vs, s_fs, int'(s_fc));
  endfunction

  function automatic obs_t f_obs();
    return mk(int'(f_col), int'(f_row), f_valid, f_hs, f_vs, f_fs, int'(f_fc));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got col=%0d row=%0d valid=%b hs=%b vs=%b fs=%b fc=%0d, want col=%0d row=%0d valid=%b hs=%b vs=%b fs=%b fc=%0d",
               name, act.col, act.row, act.valid, act.hs, act.vs, act.fs, act.fc,
               exp.col, exp.row, exp.valid, exp.hs, exp.vs, exp.fs, exp.fc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t tbl[$];
  obs_t s_rst_exp, f_rst_exp;

  initial begin
    int   lows, first_low, rise_col, fs_cnt, hs_clk, fs_rise0, fs_rise1, viol;
    obs_t prev, cur;

    s_rst_exp = mk(0, 0, 0, 1, 0, 0, 0);
    f_rst_exp = mk(0, 0, 0, 1, 1, 0, 0);

    // Reset values
    do_reset();
    chk("reset_small", s_obs(), s_rst_exp);
    chk("reset_full", f_obs(), f_rst_exp);

    // Full raster, first line
    en = 1'b1;
    step();
    chk("full_start", f_obs(), mk(0, 0, 1, 1, 1, 1, 0));
    lows = 0; first_low = -1; rise_col = -1;
    for (int i = 1; i <= 800; i++) begin
      step();
      if (!f_hs) begin
        lows++;
        if (first_low < 0) first_low = int'(f_col);
      end else if (lows > 0 && rise_col < 0) begin
        rise_col = int'(f_col);
      end
      if (i == 639) chk("full_col639", f_obs(), mk(639, 0, 1, 1, 1, 0, 0));
      if (i == 640) chk("full_col640", f_obs(), mk(640, 0, 0, 1, 1, 0, 0));
    end
    chk("full_line1", f_obs(), mk(0, 1, 1, 1, 1, 0, 0));
    chk_int("full_hs_width", lows, 96);
    chk_int("full_hs_first_low_col", first_low, 657);
    chk_int("full_hs_rise_col", rise_col, 753);

    // Small raster, table-driven scan through one frame
    tbl.push_back('{1,  1'b1, mk(0, 0, 1, 1, 0, 1, 0)});
    tbl.push_back('{7,  1'b1, mk(7, 0, 1, 1, 0, 0, 0)});
    tbl.push_back('{1,  1'b1, mk(8, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{2,  1'b1, mk(10, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{1,  1'b1, mk(11, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{2,  1'b1, mk(13, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{1,  1'b1, mk(14, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{1,  1'b1, mk(15, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{1,  1'b1, mk(0, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{5,  1'b0, mk(0, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{80, 1'b1, mk(0, 6, 0, 1, 0, 0, 0)});
    tbl.push_back('{32, 1'b1, mk(0, 8, 0, 1, 0, 0, 0)});
    tbl.push_back('{1,  1'b1, mk(1, 8, 0, 1, 1, 0, 0)});
    tbl.push_back('{3,  1'b0, mk(1, 8, 0, 1, 1, 0, 0)});
    tbl.push_back('{31, 1'b1, mk(0, 10, 0, 1, 1, 0, 0)});
    tbl.push_back('{1,  1'b1, mk(1, 10, 0, 1, 0, 0, 0)});
    tbl.push_back('{30, 1'b1, mk(15, 11, 0, 1, 0, 0, 0)});
    tbl.push_back('{1,  1'b1, mk(0, 0, 1, 1, 0, 1, 1)});
    tbl.push_back('{4,  1'b0, mk(0, 0, 1, 1, 0, 1, 1)});
    tbl.push_back('{1,  1'b1, mk(1, 0, 1, 1, 0, 0, 1)});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en;
      repeat (tbl[i].n) step();
      chk($sformatf("vec%0d", i), s_obs(), tbl[i].exp);
    end

    // Frame counter wrap: at t=193 now, frame k starts at t=192*k
    en = 1'b1;
    fs_cnt = 0;
    for (int i = 0; i < 48767; i++) begin
      step();
      if (s_fs) fs_cnt++;
    end
    chk("frame255_start", s_obs(), mk(0, 0, 1, 1, 0, 1, 255));
    chk_int("framestart_count", fs_cnt, 254);
    repeat (191) step();
    chk("frame255_last", s_obs(), mk(15, 11, 0, 1, 0, 0, 255));
    step();
    chk("frame_wrap_to0", s_obs(), mk(0, 0, 1, 1, 0, 1, 0));

    // Enable pulsed 1-in-4
    do_reset();
    prev = s_obs();
    hs_clk = 0; fs_rise0 = -1; fs_rise1 = -1; viol = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      en = (cyc % 4 == 0);
      step();
      cur = s_obs();
      if (!en && cur !== prev) viol++;
      if (cyc < 64 && !cur.hs) hs_clk++;
      if (cur.fs && !prev.fs) begin
        if (fs_rise0 < 0) fs_rise0 = cyc;
        else if (fs_rise1 < 0) fs_rise1 = cyc;
      end
      prev = cur;
    end
    chk_int("div4_hold_violations", viol, 0);
    chk_int("div4_hs_width_clocks", hs_clk, 12);
    chk_int("div4_frame_clocks", fs_rise1 - fs_rise0, 768);

    // Mid-frame reset and restart
    do_reset();
    en = 1'b1;
    step();
    repeat (53) step();
    chk("mid_frame_pos", s_obs(), mk(5, 3, 1, 1, 0, 0, 0));
    rst = 1'b1;
    step();
    chk("mid_reset_small", s_obs(), s_rst_exp);
    chk("mid_reset_full", f_obs(), f_rst_exp);
    rst = 1'b0;
    en  = 1'b0;
    repeat (5) step();
    chk("idle_hold", s_obs(), s_rst_exp);
    chk("idle_hold_full", f_obs(), f_rst_exp);
    en = 1'b1;
    step();
    chk("restart_00", s_obs(), mk(0, 0, 1, 1, 0, 1, 0));
    step();
    chk("restart_01", s_obs(), mk(1, 0, 1, 1, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
